// File: rtl/fwrisc_mem_pkg.sv
// Shared types for the fwrisc memory arbiter: controller states and request sources.
package fwrisc_mem_pkg;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    RESP,
    ACK
  } state_e;

  typedef enum logic {
    SRC_I,
    SRC_D
  } src_e;

endpackage

// File: rtl/fwrisc_mem_arbiter.sv
// Merges the fwrisc fetch and load/store ports onto one shared memory port.
// One transaction is in flight at a time; fetch and data requests are granted
// round-robin, and completion is reported back as a single-cycle ready pulse.
module fwrisc_mem_arbiter
  import fwrisc_mem_pkg::*;
(
  input  logic        clock,
  input  logic        reset,

  input  logic [31:0] iaddr,
  input  logic        ivalid,
  output logic        iready,
  output logic [31:0] idata,

  input  logic [31:0] daddr,
  input  logic [31:0] dwdata,
  input  logic [3:0]  dstrb,
  input  logic        dwrite,
  input  logic        dvalid,
  output logic        dready,
  output logic [31:0] drdata,

  output logic [31:0] maddr,
  output logic [31:0] mwdata,
  output logic [3:0]  mstrb,
  output logic        mwrite,
  output logic        mvalid,
  input  logic        mready,
  input  logic        mrvalid,
  input  logic [31:0] mrdata
);

  state_e      state;
  state_e      state_next;
  src_e        last_grant;
  src_e        req_src;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_strb;
  logic        req_write;
  logic [31:0] data_q;
  logic        grant;
  logic        grant_d;
  logic        capture;

  // Decide whether a request is granted this cycle and which side wins; on contention
  // the side that did not win last time goes first.
  always_comb begin
    grant   = (state == IDLE) && (ivalid || dvalid);
    grant_d = dvalid && (!ivalid || (last_grant == SRC_I));
    capture = ((state == REQ) && mready && !req_write && mrvalid) ||
              ((state == RESP) && mrvalid);
  end

  // State register; reset abandons whatever memory transaction was outstanding.
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic: a same-cycle read response lets the controller skip RESP.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (ivalid || dvalid) begin
          state_next = REQ;
        end
      end
      REQ: begin
        if (mready) begin
          if (req_write || mrvalid) begin
            state_next = ACK;
          end else begin
            state_next = RESP;
          end
        end
      end
      RESP: begin
        if (mrvalid) begin
          state_next = ACK;
        end
      end
      ACK: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Request latch, round-robin history and read-data capture; the memory port is
  // driven straight from these registers so it stays stable while the core changes inputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      last_grant <= SRC_I;
      req_src    <= SRC_I;
      req_addr   <= '0;
      req_wdata  <= '0;
      req_strb   <= '0;
      req_write  <= 1'b0;
      data_q     <= '0;
    end else begin
      if (grant) begin
        if (grant_d) begin
          last_grant <= SRC_D;
          req_src    <= SRC_D;
          req_addr   <= daddr & 32'hFFFF_FFFC;
          req_wdata  <= dwdata;
          req_strb   <= dwrite ? dstrb : 4'hf;
          req_write  <= dwrite;
        end else begin
          last_grant <= SRC_I;
          req_src    <= SRC_I;
          req_addr   <= iaddr & 32'hFFFF_FFFC;
          req_wdata  <= '0;
          req_strb   <= 4'hf;
          req_write  <= 1'b0;
        end
      end
      if (capture) begin
        data_q <= mrdata;
      end
    end
  end

  // Outputs decoded from registered state only, so no core input reaches memory
  // combinationally and no memory input reaches the core combinationally.
  always_comb begin
    mvalid = (state == REQ);
    iready = (state == ACK) && (req_src == SRC_I);
    dready = (state == ACK) && (req_src == SRC_D);
  end

  assign maddr  = req_addr;
  assign mwdata = req_wdata;
  assign mstrb  = req_strb;
  assign mwrite = req_write;
  assign idata  = data_q;
  assign drdata = data_q;

endmodule

// File: tb/tb_fwrisc_mem_arbiter.sv
// Directed self-checking bench for fwrisc_mem_arbiter. The memory side is driven
// cycle by cycle from the bench, and every expected value is written out by hand.
module tb_fwrisc_mem_arbiter;

  logic        clock;
  logic        reset;
  logic [31:0] iaddr;
  logic        ivalid;
  logic        iready;
  logic [31:0] idata;
  logic [31:0] daddr;
  logic [31:0] dwdata;
  logic [3:0]  dstrb;
  logic        dwrite;
  logic        dvalid;
  logic        dready;
  logic [31:0] drdata;
  logic [31:0] maddr;
  logic [31:0] mwdata;
  logic [3:0]  mstrb;
  logic        mwrite;
  logic        mvalid;
  logic        mready;
  logic        mrvalid;
  logic [31:0] mrdata;

  int testsRun;
  int testsFailed;

  fwrisc_mem_arbiter dut (
    .clock   (clock),
    .reset   (reset),
    .iaddr   (iaddr),
    .ivalid  (ivalid),
    .iready  (iready),
    .idata   (idata),
    .daddr   (daddr),
    .dwdata  (dwdata),
    .dstrb   (dstrb),
    .dwrite  (dwrite),
    .dvalid  (dvalid),
    .dready  (dready),
    .drdata  (drdata),
    .maddr   (maddr),
    .mwdata  (mwdata),
    .mstrb   (mstrb),
    .mwrite  (mwrite),
    .mvalid  (mvalid),
    .mready  (mready),
    .mrvalid (mrvalid),
    .mrdata  (mrdata)
  );

  // 10-unit free-running clock.
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
    end
  endtask

  // Drives the core-side request inputs; they are sampled at the next rising edge.
  task automatic applyStimulus(input logic iv, input logic [31:0] ia,
                               input logic dv, input logic [31:0] da,
                               input logic [31:0] dwd, input logic [3:0] ds,
                               input logic dw);
    ivalid = iv;
    iaddr  = ia;
    dvalid = dv;
    daddr  = da;
    dwdata = dwd;
    dstrb  = ds;
    dwrite = dw;
  endtask

  // Advance one cycle and settle just after the rising edge.
  task automatic nextCycle();
    @(posedge clock);
    #1;
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, " iready"}, {31'd0, iready}, 32'd0);
    checkOutput({tag, " dready"}, {31'd0, dready}, 32'd0);
    checkOutput({tag, " mvalid"}, {31'd0, mvalid}, 32'd0);
    checkOutput({tag, " mwrite"}, {31'd0, mwrite}, 32'd0);
    checkOutput({tag, " maddr"}, maddr, 32'd0);
    checkOutput({tag, " mwdata"}, mwdata, 32'd0);
    checkOutput({tag, " mstrb"}, {28'd0, mstrb}, 32'd0);
    checkOutput({tag, " idata"}, idata, 32'd0);
    checkOutput({tag, " drdata"}, drdata, 32'd0);
  endtask

  initial begin
    logic expectD;
    testsRun    = 0;
    testsFailed = 0;
    reset   = 1'b1;
    mready  = 1'b0;
    mrvalid = 1'b0;
    mrdata  = 32'd0;
    applyStimulus(1'b0, 32'd0, 1'b0, 32'd0, 32'd0, 4'd0, 1'b0);
    nextCycle();
    nextCycle();
    checkResetValues("por");
    reset = 1'b0;

    // Fetch with one-cycle memory latency.
    applyStimulus(1'b1, 32'h100, 1'b0, 32'd0, 32'd0, 4'd0, 1'b0);
    nextCycle();
    checkOutput("fetch mvalid", {31'd0, mvalid}, 32'd1);
    checkOutput("fetch maddr", maddr, 32'h100);
    checkOutput("fetch mstrb", {28'd0, mstrb}, 32'hf);
    checkOutput("fetch mwrite", {31'd0, mwrite}, 32'd0);
    mready = 1'b1;
    nextCycle();
    checkOutput("fetch resp mvalid", {31'd0, mvalid}, 32'd0);
    checkOutput("fetch resp iready", {31'd0, iready}, 32'd0);
    mready  = 1'b0;
    mrvalid = 1'b1;
    mrdata  = 32'h0000_0013;
    nextCycle();
    checkOutput("fetch iready", {31'd0, iready}, 32'd1);
    checkOutput("fetch dready", {31'd0, dready}, 32'd0);
    checkOutput("fetch idata", idata, 32'h13);
    mrvalid = 1'b0;
    applyStimulus(1'b0, 32'd0, 1'b0, 32'd0, 32'd0, 4'd0, 1'b0);
    nextCycle();
    checkOutput("fetch pulse width", {31'd0, iready}, 32'd0);

    // Store to an unaligned address with a single-byte strobe.
    applyStimulus(1'b0, 32'd0, 1'b1, 32'h203, 32'hAABB_CCDD, 4'b1000, 1'b1);
    nextCycle();
    checkOutput("store mvalid", {31'd0, mvalid}, 32'd1);
    checkOutput("store maddr", maddr, 32'h200);
    checkOutput("store mstrb", {28'd0, mstrb}, 32'h8);
    checkOutput("store mwrite", {31'd0, mwrite}, 32'd1);
    checkOutput("store mwdata", mwdata, 32'hAABB_CCDD);
    mready = 1'b1;
    nextCycle();
    checkOutput("store dready", {31'd0, dready}, 32'd1);
    checkOutput("store iready", {31'd0, iready}, 32'd0);
    mready = 1'b0;
    applyStimulus(1'b0, 32'd0, 1'b0, 32'd0, 32'd0, 4'd0, 1'b0);
    nextCycle();
    checkOutput("store pulse width", {31'd0, dready}, 32'd0);
    checkOutput("store idle mvalid", {31'd0, mvalid}, 32'd0);

    // Contention from reset: both sides held, fast memory, expect D, I, D, I.
    reset = 1'b1;
    applyStimulus(1'b1, 32'h500, 1'b1, 32'h400, 32'd0, 4'd0, 1'b0);
    nextCycle();
    reset   = 1'b0;
    mready  = 1'b1;
    mrvalid = 1'b1;
    mrdata  = 32'h5555_AAAA;
    for (int t = 0; t < 4; t++) begin
      expectD = (t % 2 == 0);
      nextCycle();
      checkOutput($sformatf("rr%0d mvalid", t), {31'd0, mvalid}, 32'd1);
      checkOutput($sformatf("rr%0d maddr", t), maddr, expectD ? 32'h400 : 32'h500);
      nextCycle();
      checkOutput($sformatf("rr%0d dready", t), {31'd0, dready}, {31'd0, expectD});
      checkOutput($sformatf("rr%0d iready", t), {31'd0, iready}, {31'd0, !expectD});
      checkOutput($sformatf("rr%0d data", t), expectD ? drdata : idata, 32'h5555_AAAA);
      nextCycle();
      checkOutput($sformatf("rr%0d idle mvalid", t), {31'd0, mvalid}, 32'd0);
    end
    applyStimulus(1'b0, 32'd0, 1'b0, 32'd0, 32'd0, 4'd0, 1'b0);
    mready  = 1'b0;
    mrvalid = 1'b0;
    nextCycle();
    checkOutput("rr drained mvalid", {31'd0, mvalid}, 32'd0);

    // Slow memory load: request fields must stay put while the core input changes.
    applyStimulus(1'b0, 32'd0, 1'b1, 32'h3000, 32'h1234_5678, 4'b0011, 1'b0);
    nextCycle();
    daddr = 32'hFFFF_FFFF;
    for (int c = 0; c < 6; c++) begin
      checkOutput($sformatf("slow c%0d mvalid", c), {31'd0, mvalid}, 32'd1);
      checkOutput($sformatf("slow c%0d maddr", c), maddr, 32'h3000);
      checkOutput($sformatf("slow c%0d mstrb", c), {28'd0, mstrb}, 32'hf);
      checkOutput($sformatf("slow c%0d dready", c), {31'd0, dready}, 32'd0);
      if (c == 5) begin
        mready = 1'b1;
      end
      nextCycle();
    end
    mready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      checkOutput($sformatf("slow wait%0d mvalid", c), {31'd0, mvalid}, 32'd0);
      checkOutput($sformatf("slow wait%0d dready", c), {31'd0, dready}, 32'd0);
      if (c == 2) begin
        mrvalid = 1'b1;
        mrdata  = 32'hCAFE_F00D;
      end
      nextCycle();
    end
    mrvalid = 1'b0;
    checkOutput("slow dready", {31'd0, dready}, 32'd1);
    checkOutput("slow drdata", drdata, 32'hCAFE_F00D);
    applyStimulus(1'b0, 32'd0, 1'b0, 32'd0, 32'd0, 4'd0, 1'b0);
    nextCycle();
    checkOutput("slow single pulse", {31'd0, dready}, 32'd0);

    // Zero-latency read: accept and response in the same cycle.
    applyStimulus(1'b0, 32'd0, 1'b1, 32'h44, 32'd0, 4'd0, 1'b0);
    nextCycle();
    mready  = 1'b1;
    mrvalid = 1'b1;
    mrdata  = 32'hDEAD_BEEF;
    nextCycle();
    mready  = 1'b0;
    mrvalid = 1'b0;
    checkOutput("zlat dready", {31'd0, dready}, 32'd1);
    checkOutput("zlat drdata", drdata, 32'hDEAD_BEEF);
    checkOutput("zlat mvalid", {31'd0, mvalid}, 32'd0);
    applyStimulus(1'b0, 32'd0, 1'b0, 32'd0, 32'd0, 4'd0, 1'b0);
    nextCycle();

    // Reset while waiting for a read response; the late response must be ignored.
    applyStimulus(1'b1, 32'h600, 1'b0, 32'd0, 32'd0, 4'd0, 1'b0);
    nextCycle();
    checkOutput("rst maddr", maddr, 32'h600);
    mready = 1'b1;
    nextCycle();
    mready = 1'b0;
    checkOutput("rst resp mvalid", {31'd0, mvalid}, 32'd0);
    checkOutput("rst resp iready", {31'd0, iready}, 32'd0);
    reset = 1'b1;
    applyStimulus(1'b0, 32'd0, 1'b0, 32'd0, 32'd0, 4'd0, 1'b0);
    nextCycle();
    checkResetValues("midrst");
    reset   = 1'b0;
    mrvalid = 1'b1;
    mrdata  = 32'h0000_0077;
    nextCycle();
    mrvalid = 1'b0;
    checkOutput("late iready", {31'd0, iready}, 32'd0);
    checkOutput("late dready", {31'd0, dready}, 32'd0);
    checkOutput("late mvalid", {31'd0, mvalid}, 32'd0);
    nextCycle();
    checkOutput("late iready2", {31'd0, iready}, 32'd0);
    checkOutput("late idata", idata, 32'd0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/fwrisc_mem_arbiter.md
# fwrisc_mem_arbiter

Merges the fwrisc core's separate instruction-fetch and data-access ports onto one shared memory port. It accepts at most one transaction at a time, arbitrates between fetch and load/store requests, and forwards each request to memory. It then returns write acknowledge or read data to the requesting port as a single-cycle ready pulse. It sits directly downstream of the core, between the core and the system memory/bus.

## Interface
Parameters:
- none

Ports:
- clock  in  1  sole clock; all logic on posedge
- reset  in  1  synchronous, active-high
- iaddr  in  32  fetch address from core
- ivalid  in  1  fetch request; held by core until iready
- iready  out  1  one-cycle pulse: idata valid this cycle
- idata  out  32  fetched instruction word
- daddr  in  32  data address from core
- dwdata  in  32  store data
- dstrb  in  4  byte strobes for stores
- dwrite  in  1  1 = store, 0 = load
- dvalid  in  1  data request; held by core until dready
- dready  out  1  one-cycle pulse: store done, or drdata valid this cycle
- drdata  out  32  load data
- maddr  out  32  memory address, bits [1:0] forced to 0
- mwdata  out  32  memory write data
- mstrb  out  4  memory byte strobes; 4'hf for reads
- mwrite  out  1  memory write enable
- mvalid  out  1  memory request; held until mready
- mready  in  1  memory accepts request
- mrvalid  in  1  read response valid; exactly one per accepted read
- mrdata  in  32  read response data

## Operation
- FSM states are IDLE, REQ, RESP and ACK. Reset enters IDLE.
- IDLE:
  - If ivalid or dvalid is high, grant one requester and latch its address, wdata, strb, write and source into request registers. Go to REQ.
  - A fetch always latches write=0 and strb=4'hf.
- Arbitration:
  - Round-robin, using a last_grant flag (reset value = I).
  - If both requests are high, grant the source that was not granted last.
  - A single request is granted immediately.
  - last_grant updates on every grant.
- REQ:
  - mvalid=1, with maddr, mwdata, mstrb and mwrite driven from the latched registers and held stable.
  - On mready with a write, go to ACK.
  - On mready with a read and mrvalid in the same cycle, capture mrdata and go to ACK.
  - On mready with a read and no mrvalid, go to RESP.
- RESP: on mrvalid, capture mrdata into the data register and go to ACK.
- ACK:
  - Pulse iready (source I) or dready (source D) for exactly one cycle, then go to IDLE.
  - idata and drdata both drive the data register. The value is meaningful only in the ACK cycle.
- mrvalid in IDLE or ACK is ignored.
- Requests seen in ACK are not sampled. They are granted in the following IDLE cycle.
- If the core drops its valid after the grant, the transaction still completes and the ready pulse is still issued.
- Reset mid-operation:
  - Any state returns to IDLE next cycle and the outstanding memory transaction is abandoned.
  - The bench guarantees memory is also reset.

## Timing
- Reset values: iready=0, dready=0, mvalid=0, mwrite=0, maddr=0, mwdata=0, mstrb=0, idata/drdata=0, last_grant=I.
- Request sampled in cycle 0 (IDLE) gives mvalid high in cycle 1.
- Write with mready in cycle 1 gives the ready pulse in cycle 2.
- Read with mready in cycle 1:
  - mrvalid in cycle 1 gives the ready pulse in cycle 2 (minimum).
  - mrvalid in cycle k ≥ 2 gives the ready pulse in cycle k+1.
- Back-to-back: the next grant occurs no earlier than the cycle after ACK. Minimum period is 3 cycles per write.
- No combinational path from any core input to any memory output, or from any memory input to any core output. All outputs are registered or decoded from registered state.

## Structure
- Package fwrisc_mem_pkg holds:
  - the state enum (IDLE, REQ, RESP, ACK)
  - the source enum (SRC_I, SRC_D)
- The block is a single module with no sub-modules. The request-latch and arbitration logic are small enough to stay inline.

## Test plan
- Fetch only: ivalid=1, iaddr=0x100; memory returns 0x00000013 with 1-cycle latency → mvalid cycle 1 with maddr=0x100, mstrb=f, mwrite=0; iready pulse cycle 3 with idata=0x13.
- Store: dvalid=1, dwrite=1, daddr=0x203, dwdata=0xAABBCCDD, dstrb=4'b1000; mready in the first REQ cycle → maddr=0x200, mstrb=4'b1000; dready pulse exactly 2 cycles after the request.
- Contention: ivalid and dvalid held together from reset for 4 transactions → grant order I? No. After reset last_grant=I, so order is D, I, D, I, with each ready pulse on the matching port only.
- Slow memory: mready held low 5 cycles, then mrvalid 3 cycles after accept → mvalid and request fields stable throughout; exactly one ready pulse.
- Zero-latency read: mready and mrvalid in the same cycle with mrdata=0xDEADBEEF → state skips RESP; drdata=0xDEADBEEF on the dready pulse the next cycle.
- Reset mid-read: assert reset while in RESP → all outputs at reset values next cycle; a late mrvalid produces no ready pulse.
